// File: rtl/ev_motor_ramp_ctrl.sv
// rtl/ev_motor_ramp_ctrl.sv - EV motor speed ramp controller with pedal conflict fault and PWM drive
module ev_motor_ramp_ctrl #(
    parameter int W            = 8,
    parameter int RAMP_DIV     = 4,
    parameter int ACCEL_STEP   = 1,
    parameter int DECEL_STEP   = 4,
    parameter int CONFLICT_CYC = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         power_on,
    input  logic [W-1:0] accel,
    input  logic [W-1:0] brake,
    input  logic         fault_clr,
    output logic [2:0]   state,
    output logic [W-1:0] speed,
    output logic         pwm,
    output logic         at_target,
    output logic         fault
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int CW = $clog2(CONFLICT_CYC + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(RAMP_DIV - 1);
    localparam logic [CW-1:0] CONF_LAST = CW'(CONFLICT_CYC - 1);
    localparam logic [CW-1:0] CONF_MAX  = CW'(CONFLICT_CYC);
    localparam logic [W-1:0]  ASTEP     = W'(ACCEL_STEP);
    localparam logic [W-1:0]  DSTEP     = W'(DECEL_STEP);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_IDLE  = 3'd1,
        S_DRIVE = 3'd2,
        S_BRAKE = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        st;
    logic [W-1:0]  spd;
    logic [W-1:0]  pwm_cnt;
    logic          pwm_q;
    logic [PW-1:0] prescaler;
    logic [CW-1:0] conf_cnt;

    logic [W-1:0]  target;
    logic          conflict;
    logic          pedals_idle;
    logic          active;
    logic          tick;
    logic          go_fault;
    logic          go_off;

    assign target      = (accel > brake) ? accel - brake : '0;
    assign conflict    = (accel != '0) && (brake != '0);
    assign pedals_idle = (accel == '0) && (brake == '0);
    assign active      = (st == S_IDLE) || (st == S_DRIVE) || (st == S_BRAKE);
    assign tick        = active && (prescaler == PRE_LAST);
    // Fault outranks power-off, so both are resolved before the per-state transitions.
    assign go_fault    = (st != S_FAULT) && conflict && (conf_cnt >= CONF_LAST);
    assign go_off      = active && !power_on;

    assign state     = st;
    assign speed     = spd;
    assign pwm       = pwm_q;
    assign at_target = (st == S_DRIVE) && (spd == target);
    assign fault     = (st == S_FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_OFF;
            spd       <= '0;
            pwm_cnt   <= '0;
            pwm_q     <= 1'b0;
            prescaler <= '0;
            conf_cnt  <= '0;
        end else if (ena) begin
            if (!conflict) begin
                conf_cnt <= '0;
            end else if (conf_cnt != CONF_MAX) begin
                conf_cnt <= conf_cnt + 1'b1;
            end

            if (go_fault || go_off) begin
                st        <= go_fault ? S_FAULT : S_OFF;
                spd       <= '0;
                pwm_cnt   <= '0;
                pwm_q     <= 1'b0;
                prescaler <= '0;
            end else begin
                case (st)
                    S_OFF:   if (power_on) st <= S_IDLE;
                    S_IDLE:  if (target != '0) st <= S_DRIVE;
                    S_DRIVE: begin
                        if ((brake != '0) && (brake >= accel)) st <= S_BRAKE;
                        else if (pedals_idle && (spd == '0))    st <= S_IDLE;
                    end
                    S_BRAKE: begin
                        if (accel > brake)    st <= S_DRIVE;
                        else if (spd == '0)   st <= S_IDLE;
                    end
                    S_FAULT: if (fault_clr && pedals_idle) st <= power_on ? S_IDLE : S_OFF;
                    default: st <= S_OFF;
                endcase

                if (active) begin
                    prescaler <= tick ? '0 : prescaler + 1'b1;
                    pwm_cnt   <= pwm_cnt + 1'b1;
                    pwm_q     <= (pwm_cnt < spd);
                end else begin
                    prescaler <= '0;
                    pwm_cnt   <= '0;
                    pwm_q     <= 1'b0;
                end

                // Steps are clamped to the remaining distance so the ramp lands exactly on target.
                if (st == S_DRIVE) begin
                    if (tick) begin
                        if (spd < target)
                            spd <= ((target - spd) > ASTEP) ? spd + ASTEP : target;
                        else if (spd > target)
                            spd <= ((spd - target) > DSTEP) ? spd - DSTEP : target;
                    end
                end else if (st == S_BRAKE) begin
                    if (tick) spd <= (spd > DSTEP) ? spd - DSTEP : '0;
                end else begin
                    spd <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ev_motor_ramp_ctrl.sv
// tb/tb_ev_motor_ramp_ctrl.sv - scenario bench for ev_motor_ramp_ctrl with a queue scoreboard
module tb_ev_motor_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       power_on = 1'b0;
    logic [7:0] accel = 8'd0;
    logic [7:0] brake = 8'd0;
    logic       fault_clr = 1'b0;
    logic [2:0] state;
    logic [7:0] speed;
    logic       pwm;
    logic       at_target;
    logic       fault;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    ev_motor_ramp_ctrl #(
        .W(8), .RAMP_DIV(4), .ACCEL_STEP(1), .DECEL_STEP(4), .CONFLICT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .power_on(power_on),
        .accel(accel), .brake(brake), .fault_clr(fault_clr),
        .state(state), .speed(speed), .pwm(pwm),
        .at_target(at_target), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        vectors++; if (speed !== 8'd0) begin miscompares++; $display("FAIL reset_speed: got %0d expected 0", speed); end
        vectors++; if (pwm !== 1'b0) begin miscompares++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", fault); end
        vectors++; if (at_target !== 1'b0) begin miscompares++; $display("FAIL reset_at_target: got %b expected 0", at_target); end
    endtask

    task automatic test_ramp_up();
        logic [7:0] prev;
        logic [7:0] e;
        int last_chg;
        bit over;
        power_on = 1'b1; accel = 8'd8; brake = 8'd0;
        step();
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL ramp_idle: got %0d expected 1", state); end
        step();
        vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL ramp_drive: got %0d expected 2", state); end
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        prev = 8'd0; last_chg = -1; over = 1'b0;
        for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
            step();
            if (speed > 8'd8) over = 1'b1;
            if (speed !== prev) begin
                e = exp_q.pop_front();
                vectors++; if (speed !== e) begin miscompares++; $display("FAIL ramp_speed: got %0d expected %0d", speed, e); end
                if (last_chg >= 0) begin
                    vectors++; if (cyc - last_chg != 4) begin miscompares++; $display("FAIL ramp_interval: got %0d expected 4", cyc - last_chg); end
                end
                last_chg = cyc; prev = speed;
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ramp_timeout: got %0d pending expected 0", exp_q.size()); end
        exp_q.delete();
        repeat (8) begin step(); if (speed > 8'd8) over = 1'b1; end
        vectors++; if (over) begin miscompares++; $display("FAIL ramp_overshoot: got over expected <=8"); end
        vectors++; if (speed !== 8'd8) begin miscompares++; $display("FAIL ramp_final: got %0d expected 8", speed); end
        vectors++; if (at_target !== 1'b1) begin miscompares++; $display("FAIL ramp_at_target: got %b expected 1", at_target); end
    endtask

    task automatic test_brake();
        logic [7:0] prev;
        logic [7:0] e;
        brake = 8'd8;
        step();
        vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL brake_state: got %0d expected 3", state); end
        exp_q.push_back(8'd4); exp_q.push_back(8'd0);
        prev = 8'd8;
        for (int c = 0; c < 20; c++) begin
            if (speed !== prev) begin
                e = exp_q.pop_front();
                vectors++; if (speed !== e) begin miscompares++; $display("FAIL brake_speed: got %0d expected %0d", speed, e); end
                prev = speed;
            end
            if (exp_q.size() == 0) break;
            step();
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL brake_timeout: got %0d pending expected 0", exp_q.size()); end
        exp_q.delete();
        for (int c = 0; c < 4 && state !== 3'd1; c++) step();
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL brake_idle: got %0d expected 1", state); end
        vectors++; if (speed !== 8'd0) begin miscompares++; $display("FAIL brake_idle_speed: got %0d expected 0", speed); end
        accel = 8'd0; brake = 8'd0;
        step(); step();
    endtask

    task automatic test_conflict();
        bit early;
        accel = 8'd5; brake = 8'd3;
        early = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (state === 3'd4) early = 1'b1;
        end
        vectors++; if (early) begin miscompares++; $display("FAIL conflict_early: got fault before 16 cycles expected none"); end
        step();
        vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL conflict_state: got %0d expected 4", state); end
        vectors++; if (speed !== 8'd0) begin miscompares++; $display("FAIL conflict_speed: got %0d expected 0", speed); end
        vectors++; if (pwm !== 1'b0) begin miscompares++; $display("FAIL conflict_pwm: got %b expected 0", pwm); end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL conflict_fault: got %b expected 1", fault); end
        fault_clr = 1'b1;
        step(); step();
        vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL clr_with_pedals: got %0d expected 4", state); end
        fault_clr = 1'b0; power_on = 1'b0;
        step(); step();
        vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL poweroff_in_fault: got %0d expected 4", state); end
        power_on = 1'b1; accel = 8'd0; brake = 8'd0; fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL fault_exit: got %0d expected 1", state); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_exit_flag: got %b expected 0", fault); end
    endtask

    task automatic test_pwm_duty();
        int highs;
        logic [7:0] e;
        accel = 8'd64;
        for (int c = 0; c < 600 && at_target !== 1'b1; c++) step();
        vectors++; if (speed !== 8'd64) begin miscompares++; $display("FAIL pwm_settle: got %0d expected 64", speed); end
        step();
        exp_q.push_back(8'd64);
        highs = 0;
        for (int c = 0; c < 256; c++) begin step(); if (pwm === 1'b1) highs++; end
        e = exp_q.pop_front();
        vectors++; if (highs != int'(e)) begin miscompares++; $display("FAIL pwm_duty64: got %0d expected %0d", highs, e); end
        accel = 8'd0;
        for (int c = 0; c < 200 && state !== 3'd1; c++) step();
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL pwm_decel_idle: got %0d expected 1", state); end
        exp_q.push_back(8'd0);
        highs = 0;
        for (int c = 0; c < 256; c++) begin step(); if (pwm !== 1'b0) highs++; end
        e = exp_q.pop_front();
        vectors++; if (highs != int'(e)) begin miscompares++; $display("FAIL pwm_duty0: got %0d expected %0d", highs, e); end
    endtask

    task automatic test_power_drop();
        logic [7:0] e;
        accel = 8'd20;
        for (int c = 0; c < 300 && speed !== 8'd20; c++) step();
        vectors++; if (speed !== 8'd20 || state !== 3'd2) begin miscompares++; $display("FAIL drop_setup: got speed %0d state %0d expected 20 and 2", speed, state); end
        power_on = 1'b0;
        step();
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL drop_off: got %0d expected 0", state); end
        vectors++; if (speed !== 8'd0) begin miscompares++; $display("FAIL drop_speed: got %0d expected 0", speed); end
        power_on = 1'b1;
        step();
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL repower_idle: got %0d expected 1", state); end
        step();
        vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL repower_drive: got %0d expected 2", state); end
        vectors++; if (speed !== 8'd0) begin miscompares++; $display("FAIL repower_speed: got %0d expected 0", speed); end
        exp_q.push_back(8'd1);
        for (int c = 0; c < 10 && speed === 8'd0; c++) step();
        e = exp_q.pop_front();
        vectors++; if (speed !== e) begin miscompares++; $display("FAIL repower_ramp: got %0d expected %0d", speed, e); end
    endtask

    task automatic test_enable_and_reset();
        logic [7:0] s_speed;
        logic [7:0] s_cnt;
        logic [2:0] s_state;
        logic [7:0] e;
        step(); step();
        ena = 1'b0;
        s_speed = speed; s_state = state; s_cnt = dut.pwm_cnt;
        for (int c = 0; c < 10; c++) begin
            step();
            vectors++; if (speed !== s_speed) begin miscompares++; $display("FAIL hold_speed: got %0d expected %0d", speed, s_speed); end
            vectors++; if (state !== s_state) begin miscompares++; $display("FAIL hold_state: got %0d expected %0d", state, s_state); end
            vectors++; if (dut.pwm_cnt !== s_cnt) begin miscompares++; $display("FAIL hold_pwm_cnt: got %0d expected %0d", dut.pwm_cnt, s_cnt); end
        end
        ena = 1'b1;
        exp_q.push_back(s_speed + 8'd1);
        for (int c = 0; c < 8 && speed === s_speed; c++) step();
        e = exp_q.pop_front();
        vectors++; if (speed !== e) begin miscompares++; $display("FAIL resume_ramp: got %0d expected %0d", speed, e); end
        accel = 8'd5; brake = 8'd3;
        repeat (16) step();
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL refault: got %b expected 1", fault); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL rst_fault_state: got %0d expected 0", state); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault_flag: got %b expected 0", fault); end
        vectors++; if (speed !== 8'd0) begin miscompares++; $display("FAIL rst_fault_speed: got %0d expected 0", speed); end
        accel = 8'd0; brake = 8'd0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_brake();
        test_conflict();
        test_pwm_duty();
        test_power_drop();
        test_enable_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ev_motor_ramp_ctrl.md
EV_MOTOR_RAMP_CTRL -- requirements
Module: ev_motor_ramp_ctrl

Interface
REQ-001 SHALL provide parameter W, default 8: pedal/speed width in bits.
REQ-002 SHALL provide parameter RAMP_DIV, default 4: clock cycles per ramp tick, minimum 1.
REQ-003 SHALL provide parameter ACCEL_STEP, default 1: maximum speed increase per tick.
REQ-004 SHALL provide parameter DECEL_STEP, default 4: maximum speed decrease per tick.
REQ-005 SHALL provide parameter CONFLICT_CYC, default 16: consecutive both-pedal cycles before fault.
REQ-006 SHALL provide port clk  in  1  single clock, all logic on the rising edge.
REQ-007 SHALL provide port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL provide port ena  in  1  clock enable; when low, every register holds.
REQ-009 SHALL provide port power_on  in  1  system power request.
REQ-010 SHALL provide port accel  in  W  accelerator pedal.
REQ-011 SHALL provide port brake  in  W  brake pedal.
REQ-012 SHALL provide port fault_clr  in  1  fault acknowledge.
REQ-013 SHALL provide port state  out  3  state code: OFF=0, IDLE=1, DRIVE=2, BRAKE=3, FAULT=4.
REQ-014 SHALL provide port speed  out  W  registered motor speed command.
REQ-015 SHALL provide port pwm  out  1  registered PWM drive.
REQ-016 SHALL provide port at_target  out  1  high when state==DRIVE and speed==target.
REQ-017 SHALL provide port fault  out  1  high while state==FAULT.

Function
REQ-018 SHALL compute target combinationally: accel-brake when accel>brake, else 0; no wrap.
REQ-019 SHALL keep conflict counter conf_cnt: +1 (saturating) each enabled cycle with accel!=0 and brake!=0; otherwise cleared to 0.
REQ-020 SHALL enter FAULT from any non-FAULT state on the cycle after conf_cnt reaches CONFLICT_CYC-1 with the conflict still present. Priority: fault > power-off > others.
REQ-021 SHALL go to OFF from IDLE/DRIVE/BRAKE the cycle after power_on=0.
REQ-022 SHALL transition OFF->IDLE when power_on=1.
REQ-023 SHALL transition IDLE->DRIVE when target>0.
REQ-024 SHALL transition DRIVE->BRAKE when brake!=0 and brake>=accel.
REQ-025 SHALL transition DRIVE->IDLE when accel==0, brake==0 and speed==0.
REQ-026 SHALL transition BRAKE->DRIVE when accel>brake; SHALL transition BRAKE->IDLE when speed==0 and accel<=brake.
REQ-027 SHALL leave FAULT only on fault_clr=1 with accel==0 and brake==0: to IDLE if power_on=1, else to OFF. power_on=0 alone SHALL NOT exit FAULT.
REQ-028 SHALL run ramp prescaler 0..RAMP_DIV-1 in IDLE/DRIVE/BRAKE; tick when prescaler==RAMP_DIV-1; prescaler is 0 in OFF/FAULT.
REQ-029 SHALL, on a DRIVE tick: speed += min(ACCEL_STEP, target-speed) if speed<target; speed -= min(DECEL_STEP, speed-target) if speed>target; never overshoot target.
REQ-030 SHALL, on a BRAKE tick: speed -= min(DECEL_STEP, speed); never underflow.
REQ-031 SHALL force speed to 0 the cycle OFF or FAULT is entered, and hold it 0 in OFF, IDLE and FAULT.
REQ-032 SHALL run a W-bit free-running pwm_cnt that wraps 2^W-1 -> 0; pwm <= (pwm_cnt < speed). pwm_cnt and pwm are held at 0 in OFF/FAULT.
REQ-033 SHALL set pwm duty to speed/2^W: 0 gives constant low; 2^W-1 gives one low cycle per period.
REQ-034 SHALL freeze all state, counters and outputs while ena=0, including mid-ramp and mid-conflict count.

Reset
REQ-035 SHALL, on rst=1 at a clock edge regardless of ena, set: state=OFF, speed=0, pwm=0, fault=0, prescaler=0, pwm_cnt=0, conf_cnt=0. at_target SHALL follow as 0.
REQ-036 SHALL, when rst is asserted mid-ramp or in FAULT, return to OFF in one cycle with no residual speed.

Verification
REQ-037 SHALL check ramp-up: reset, power_on=1, accel=8, brake=0 -> OFF, IDLE, DRIVE; speed +1 every 4 cycles to 8, never >8; at_target=1 at 8.
REQ-038 SHALL check braking: at speed=8, brake=8 -> BRAKE; speed 8, 4, 0 on successive ticks; then IDLE with speed=0.
REQ-039 SHALL check conflict fault: accel=5, brake=3 held for 16 cycles -> FAULT, speed=0, pwm=0. fault_clr with pedals nonzero -> stays FAULT. Pedals released plus fault_clr -> IDLE.
REQ-040 SHALL check PWM duty: speed settled at 64 (W=8) -> pwm high exactly 64 of every 256 cycles; at speed 0, pwm constantly 0.
REQ-041 SHALL check power drop: power_on=0 in DRIVE at speed=20 -> OFF next cycle, speed=0; power_on=1 with accel held -> IDLE then DRIVE, ramp restarts from 0.
REQ-042 SHALL check enable and reset: ena=0 for 10 cycles mid-ramp -> speed, state and pwm_cnt unchanged; rst=1 during FAULT -> OFF, fault=0 after one edge.
